i2c_target_regs: RTL and testbench

I2C target (responder) with an 8-bit register pointer, for bring-up and loopback of the codec-configuration I2C path. It oversamples SCL/SDA on the system clock and ACKs its 7-bit address. Write data goes out as one-cycle register-write strobes with pointer auto-increment; read data is shifted back when reads are compiled in. It sits beside or in place of the codec on the I2C bus, driven by the board's init initiator or a testbench.

---
 rtl/i2c_target_regs.sv | 189 ++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target_regs.sv
// rtl/i2c_target_regs.sv - I2C target with 8-bit register pointer and write strobes
// Read path (RDATA/RDATA_ACK) is built only when I2C_TARGET_READ_EN is defined.
module i2c_target_regs #(
   parameter logic [6:0] ADDR        = 7'h10,
   parameter int         N_REGS      = 32,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_out,
   output logic       reg_wr_valid,
   output logic [7:0] reg_wr_addr,
   output logic [7:0] reg_wr_data,
   output logic [7:0] reg_rd_addr,
   input  logic [7:0] reg_rd_data,
   output logic       busy
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
      ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] scl_ff, sda_ff;
   logic                   scl_q, sda_q;
   logic                   scl_s, sda_s;
   logic                   scl_rise, scl_fall, start_det, stop_det;
   logic [7:0]             sh, ptr, next_ptr, byte_in;
   logic [3:0]             cnt;
   logic                   addr_match, ptr_ok;

`ifdef I2C_TARGET_READ_EN
   logic rw, mack;
`else
   logic rd_unused;
   assign rd_unused = ^reg_rd_data;
`endif

   assign scl_s = scl_ff[SYNC_STAGES-1];
   assign sda_s = sda_ff[SYNC_STAGES-1];

   // START/STOP need SCL high on both sides of the SDA change, so a
   // simultaneous SCL/SDA change is treated as ordinary data movement.
   assign scl_rise  = scl_s & ~scl_q;
   assign scl_fall  = ~scl_s & scl_q;
   assign start_det = scl_s & scl_q & sda_q & ~sda_s;
   assign stop_det  = scl_s & scl_q & ~sda_q & sda_s;

   assign byte_in     = {sh[6:0], sda_s};
   assign addr_match  = (sh[7:1] == ADDR);
   assign ptr_ok      = ({1'b0, sh} < 9'(N_REGS));
   assign next_ptr    = ({1'b0, ptr} == 9'(N_REGS - 1)) ? 8'd0 : ptr + 8'd1;
   assign reg_rd_addr = ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_ff       <= '1;
         sda_ff       <= '1;
         scl_q        <= 1'b1;
         sda_q        <= 1'b1;
         state        <= ST_IDLE;
         sda_out      <= 1'b1;
         reg_wr_valid <= 1'b0;
         reg_wr_addr  <= 8'd0;
         reg_wr_data  <= 8'd0;
         busy         <= 1'b0;
         ptr          <= 8'd0;
         sh           <= 8'd0;
         cnt          <= 4'd0;
`ifdef I2C_TARGET_READ_EN
         rw           <= 1'b0;
         mack         <= 1'b0;
`endif
      end else begin
         scl_ff       <= {scl_ff[SYNC_STAGES-2:0], scl_in};
         sda_ff       <= {sda_ff[SYNC_STAGES-2:0], sda_in};
         scl_q        <= scl_s;
         sda_q        <= sda_s;
         reg_wr_valid <= 1'b0;
         if (start_det) begin
            state   <= ST_ADDR;
            cnt     <= 4'd0;
            sda_out <= 1'b1;
            busy    <= 1'b1;
         end else if (stop_det) begin
            state   <= ST_IDLE;
            sda_out <= 1'b1;
            busy    <= 1'b0;
         end else begin
            case (state)
               ST_ADDR, ST_PTR, ST_WDATA: begin
                  if (scl_rise && cnt != 4'd8) begin
                     sh  <= byte_in;
                     cnt <= cnt + 4'd1;
                     if (state == ST_WDATA && cnt == 4'd7) begin
                        reg_wr_valid <= 1'b1;
                        reg_wr_addr  <= ptr;
                        reg_wr_data  <= byte_in;
                     end
                  end else if (scl_fall && cnt == 4'd8) begin
                     cnt <= 4'd0;
                     if (state == ST_ADDR) begin
`ifdef I2C_TARGET_READ_EN
                        rw <= sh[0];
                        if (addr_match) begin
`else
                        if (addr_match && !sh[0]) begin
`endif
                           sda_out <= 1'b0;
                           state   <= ST_ADDR_ACK;
                        end else begin
                           state <= ST_IGNORE;
                        end
                     end else if (state == ST_PTR) begin
                        if (ptr_ok) begin
                           ptr     <= sh;
                           sda_out <= 1'b0;
                           state   <= ST_PTR_ACK;
                        end else begin
                           state <= ST_IGNORE;
                        end
                     end else begin
                        ptr     <= next_ptr;
                        sda_out <= 1'b0;
                        state   <= ST_WDATA_ACK;
                     end
                  end
               end
               ST_ADDR_ACK: if (scl_fall) begin
                  cnt <= 4'd0;
`ifdef I2C_TARGET_READ_EN
                  if (rw) begin
                     sh      <= reg_rd_data;
                     sda_out <= reg_rd_data[7];
                     state   <= ST_RDATA;
                  end else begin
                     sda_out <= 1'b1;
                     state   <= ST_PTR;
                  end
`else
                  sda_out <= 1'b1;
                  state   <= ST_PTR;
`endif
               end
               ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                  cnt     <= 4'd0;
                  sda_out <= 1'b1;
                  state   <= ST_WDATA;
               end
`ifdef I2C_TARGET_READ_EN
               ST_RDATA: begin
                  if (scl_rise && cnt != 4'd8) begin
                     cnt <= cnt + 4'd1;
                  end else if (scl_fall) begin
                     if (cnt == 4'd8) begin
                        sda_out <= 1'b1;
                        ptr     <= next_ptr;
                        state   <= ST_RDATA_ACK;
                     end else begin
                        sda_out <= sh[6];
                        sh      <= {sh[6:0], 1'b0};
                     end
                  end
               end
               ST_RDATA_ACK: begin
                  if (scl_rise) begin
                     mack <= ~sda_s;
                  end else if (scl_fall) begin
                     cnt <= 4'd0;
                     if (mack) begin
                        sh      <= reg_rd_data;
                        sda_out <= reg_rd_data[7];
                        state   <= ST_RDATA;
                     end else begin
                        state <= ST_IGNORE;
                     end
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb/tb_i2c_target_regs.sv - scoreboard bench for i2c_target_regs at 8 clk per SCL period
// Read expectations follow I2C_TARGET_READ_EN.
module tb_i2c_target_regs;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl_drv = 1'b1;
   logic       sda_drv = 1'b1;
   logic       sda_out, reg_wr_valid, busy;
   logic [7:0] reg_wr_addr, reg_wr_data, reg_rd_addr, reg_rd_data;
   logic       sda_bus;

   int n_vec = 0;
   int n_miss = 0;
   int strobe_cnt = 0;
   logic sda_low_seen = 1'b0;

   logic [15:0] exp_wr[$];
   logic [7:0]  exp_bus[$];
   string       exp_name[$];
   logic [7:0]  obs_bus[$];

   assign sda_bus     = sda_drv & sda_out;
   assign reg_rd_data = ~reg_rd_addr;

   always #5 clk = ~clk;

   i2c_target_regs #(.ADDR(7'h10), .N_REGS(32), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .scl_in(scl_drv), .sda_in(sda_bus), .sda_out(sda_out),
      .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
      .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data), .busy(busy)
   );

   function automatic void check(string nm, int act, int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endfunction

   // Write-strobe scoreboard
   always @(negedge clk) begin
      if (!rst && reg_wr_valid) begin
         strobe_cnt++;
         n_vec++;
         if (exp_wr.size() == 0) begin
            n_miss++;
            $display("FAIL strobe_unexpected: got addr 0x%h data 0x%h, expected none", reg_wr_addr, reg_wr_data);
         end else begin
            logic [15:0] e;
            e = exp_wr.pop_front();
            if ({reg_wr_addr, reg_wr_data} !== e) begin
               n_miss++;
               $display("FAIL strobe: got addr 0x%h data 0x%h, expected addr 0x%h data 0x%h",
                        reg_wr_addr, reg_wr_data, e[15:8], e[7:0]);
            end
         end
      end
      if (!rst && !sda_out) sda_low_seen = 1'b1;
   end

   // Bus observation scoreboard (ACK bits and read bytes)
   always @(negedge clk) begin
      if (obs_bus.size() > 0) begin
         logic [7:0] got;
         got = obs_bus.pop_front();
         n_vec++;
         if (exp_bus.size() == 0) begin
            n_miss++;
            $display("FAIL bus_unexpected: got 0x%h, expected nothing", got);
         end else begin
            logic [7:0] e;
            string nm;
            e  = exp_bus.pop_front();
            nm = exp_name.pop_front();
            if (got !== e) begin
               n_miss++;
               $display("FAIL %s: got 0x%h, expected 0x%h", nm, got, e);
            end
         end
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_bit(input logic b, output logic rb);
      wait_clk(2); sda_drv = b;
      wait_clk(2); scl_drv = 1'b1;
      wait_clk(4); rb = sda_bus; scl_drv = 1'b0;
   endtask

   task automatic i2c_start();
      wait_clk(2); sda_drv = 1'b1;
      wait_clk(2); scl_drv = 1'b1;
      wait_clk(4); sda_drv = 1'b0;
      wait_clk(4); scl_drv = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_clk(2); sda_drv = 1'b0;
      wait_clk(2); scl_drv = 1'b1;
      wait_clk(4); sda_drv = 1'b1;
      wait_clk(8);
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic ack, input string nm);
      logic r;
      exp_bus.push_back({7'd0, ack});
      exp_name.push_back(nm);
      for (int i = 7; i >= 0; i--) scl_bit(b[i], r);
      scl_bit(1'b1, r);
      obs_bus.push_back({7'd0, ~r});
   endtask

   task automatic rd_byte(input logic [7:0] e, input logic mack, input string nm);
      logic r;
      logic [7:0] v;
      v = 8'd0;
      exp_bus.push_back(e);
      exp_name.push_back(nm);
      for (int i = 7; i >= 0; i--) begin
         scl_bit(1'b1, r);
         v = {v[6:0], r};
      end
      scl_bit(~mack, r);
      obs_bus.push_back(v);
   endtask

   task automatic exp_strobe(input logic [7:0] a, input logic [7:0] d);
      exp_wr.push_back({a, d});
   endtask

   logic [7:0] codec [21] = '{8'h97, 8'h97, 8'h79, 8'h79, 8'h0A, 8'h00, 8'h62,
                              8'h43, 8'h01, 8'h00, 8'h0F, 8'h1E, 8'h2D, 8'h3C,
                              8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96, 8'hA5};

   initial begin
      int s0;
      logic r;

      wait_clk(4);
      check("rst_sda_out", sda_out, 1);
      check("rst_wr_valid", reg_wr_valid, 0);
      check("rst_wr_addr", reg_wr_addr, 0);
      check("rst_wr_data", reg_wr_data, 0);
      check("rst_rd_addr", reg_rd_addr, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      wait_clk(8);

      // Basic write with auto-increment
      s0 = strobe_cnt;
      exp_strobe(8'h03, 8'hA5);
      exp_strobe(8'h04, 8'h5A);
      i2c_start();
      wait_clk(2);
      check("busy_after_start", busy, 1);
      wr_byte(8'h20, 1'b1, "ack_addr_20");
      wr_byte(8'h03, 1'b1, "ack_ptr_03");
      wr_byte(8'hA5, 1'b1, "ack_data_A5");
      wr_byte(8'h5A, 1'b1, "ack_data_5A");
      i2c_stop();
      check("busy_after_stop", busy, 0);
      check("strobes_basic", strobe_cnt - s0, 2);
      check("rd_addr_after_write", reg_rd_addr, 8'h05);

      // Wrong address
      s0 = strobe_cnt;
      sda_low_seen = 1'b0;
      i2c_start();
      wr_byte(8'h22, 1'b0, "nack_addr_22");
      wr_byte(8'h03, 1'b0, "nack_ignored_data");
      i2c_stop();
      check("sda_never_low_mismatch", sda_low_seen, 0);
      check("strobes_mismatch", strobe_cnt - s0, 0);

      // Pointer wrap at N_REGS-1
      s0 = strobe_cnt;
      exp_strobe(8'h1F, 8'h11);
      exp_strobe(8'h00, 8'h22);
      i2c_start();
      wr_byte(8'h20, 1'b1, "ack_addr_wrap");
      wr_byte(8'h1F, 1'b1, "ack_ptr_1F");
      wr_byte(8'h11, 1'b1, "ack_data_11");
      wr_byte(8'h22, 1'b1, "ack_data_22");
      i2c_stop();
      check("strobes_wrap", strobe_cnt - s0, 2);

      // Out-of-range pointer
      s0 = strobe_cnt;
      i2c_start();
      wr_byte(8'h20, 1'b1, "ack_addr_oor");
      wr_byte(8'h40, 1'b0, "nack_ptr_40");
      wr_byte(8'h33, 1'b0, "nack_data_after_oor");
      i2c_stop();
      check("strobes_oor", strobe_cnt - s0, 0);
      check("ptr_kept_after_oor", reg_rd_addr, 8'h01);

      // Read path
      i2c_start();
      wr_byte(8'h20, 1'b1, "ack_addr_rdptr");
      wr_byte(8'h05, 1'b1, "ack_ptr_05");
      i2c_start();
`ifdef I2C_TARGET_READ_EN
      wr_byte(8'h21, 1'b1, "ack_addr_read");
      rd_byte(8'hFA, 1'b1, "read_byte0");
      rd_byte(8'hF9, 1'b0, "read_byte1");
      wait_clk(4);
      check("sda_released_after_nack", sda_out, 1);
      i2c_stop();
      check("ptr_after_read", reg_rd_addr, 8'h07);
`else
      wr_byte(8'h21, 1'b0, "nack_addr_read");
      i2c_stop();
      check("ptr_after_read_nack", reg_rd_addr, 8'h05);
`endif

      // Reset in the middle of a data byte
      s0 = strobe_cnt;
      i2c_start();
      wr_byte(8'h20, 1'b1, "ack_addr_rst");
      wr_byte(8'h02, 1'b1, "ack_ptr_rst");
      for (int i = 0; i < 4; i++) scl_bit(i < 2, r);
      rst = 1'b1;
      wait_clk(1);
      check("sda_out_after_rst", sda_out, 1);
      check("busy_after_rst", busy, 0);
      check("rd_addr_after_rst", reg_rd_addr, 0);
      rst = 1'b0;
      wait_clk(8);
      check("strobes_partial_rst", strobe_cnt - s0, 0);
      exp_strobe(8'h02, 8'h77);
      i2c_start();
      wr_byte(8'h20, 1'b1, "ack_addr_post_rst");
      wr_byte(8'h02, 1'b1, "ack_ptr_post_rst");
      wr_byte(8'h77, 1'b1, "ack_data_post_rst");
      i2c_stop();
      check("strobes_post_rst", strobe_cnt - s0, 1);

      // Codec-init stream: 23 bytes, 21 strobes
      s0 = strobe_cnt;
      for (int i = 0; i < 21; i++) exp_strobe(8'(i), codec[i]);
      i2c_start();
      wr_byte(8'h20, 1'b1, "ack_codec_addr");
      wr_byte(8'h00, 1'b1, "ack_codec_ptr");
      for (int i = 0; i < 21; i++) wr_byte(codec[i], 1'b1, "ack_codec_data");
      i2c_stop();
      check("strobes_codec", strobe_cnt - s0, 21);

      wait_clk(20);
      check("wr_queue_drained", exp_wr.size(), 0);
      check("bus_queue_drained", exp_bus.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
